// File: rtl/rx_ring_pkg.sv
// rtl/rx_ring_pkg.sv - shared widths and types for the receive ring RAM
package rx_ring_pkg;

  localparam int RX_RING_ADDR_WIDTH = 5;
  localparam int RX_RING_DATA_WIDTH = 48;
  localparam int RX_RING_BE_WIDTH   = 6;
  localparam int RX_RING_BYTE_SIZE  = 8;

  typedef logic [RX_RING_ADDR_WIDTH-1:0] rx_ring_addr_t;
  typedef logic [RX_RING_DATA_WIDTH-1:0] rx_ring_word_t;

endpackage

// File: rtl/rx_ring_ram_if.sv
// rtl/rx_ring_ram_if.sv - write/read port bundle of the receive ring RAM
interface rx_ring_ram_if
  import rx_ring_pkg::*;
#(
  parameter int ADDR_WIDTH = RX_RING_ADDR_WIDTH,
  parameter int DATA_WIDTH = RX_RING_DATA_WIDTH,
  parameter int BE_WIDTH   = RX_RING_BE_WIDTH
);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_byte_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, wr_byte_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_byte_en, rd_addr,
    output rd_data
  );

endinterface

// File: rtl/rx_ring_lane.sv
// rtl/rx_ring_lane.sv - one byte-wide slice of the ring array
// Read is combinational here; the top-level read register makes it read-first.
module rx_ring_lane #(
  parameter int ADDR_WIDTH = 5,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [BYTE_SIZE-1:0]  wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [BYTE_SIZE-1:0]  rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [BYTE_SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_ring_ram.sv
// rtl/rx_ring_ram.sv - 32x48 simple-dual-port receive ring RAM with byte enables
// Reset clears only the read pipeline; the array and writes are unaffected by rst.
module rx_ring_ram
  import rx_ring_pkg::*;
#(
  parameter int ADDR_WIDTH = RX_RING_ADDR_WIDTH,
  parameter int DATA_WIDTH = RX_RING_DATA_WIDTH,
  parameter int BE_WIDTH   = RX_RING_BE_WIDTH,
  parameter int BYTE_SIZE  = RX_RING_BYTE_SIZE,
  parameter int OUTPUT_REG = 0
) (
  input logic          clk,
  input logic          rst,
  rx_ring_ram_if.slave bus
);

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_stage1_d;
  logic [DATA_WIDTH-1:0] rd_stage1_q;

  for (genvar g = 0; g < BE_WIDTH; g++) begin : g_lane
    rx_ring_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYTE_SIZE  (BYTE_SIZE)
    ) u_lane (
      .clk_i   (clk),
      .we_i    (bus.wr_en & bus.wr_byte_en[g]),
      .waddr_i (bus.wr_addr),
      .wdata_i (bus.wr_data[g*BYTE_SIZE +: BYTE_SIZE]),
      .raddr_i (bus.rd_addr),
      .rdata_o (rd_word[g*BYTE_SIZE +: BYTE_SIZE])
    );
  end

  always_comb begin
    rd_stage1_d = rd_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_stage1_q <= '0;
    end else begin
      rd_stage1_q <= rd_stage1_d;
    end
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd_stage2_d;
    logic [DATA_WIDTH-1:0] rd_stage2_q;

    always_comb begin
      rd_stage2_d = rd_stage1_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_stage2_q <= '0;
      end else begin
        rd_stage2_q <= rd_stage2_d;
      end
    end

    assign bus.rd_data = rd_stage2_q;
  end else begin : g_no_out_reg
    assign bus.rd_data = rd_stage1_q;
  end

endmodule

// File: tb/tb_rx_ring_ram.sv
// tb/tb_rx_ring_ram.sv - scoreboard bench for rx_ring_ram, latency-1 and latency-2 builds
module tb_rx_ring_ram;
  import rx_ring_pkg::*;

  typedef struct {
    rx_ring_word_t data;
    bit            chk;
    string         tag;
  } sb_item_t;

  logic clk;
  logic rst;

  rx_ring_ram_if #(.ADDR_WIDTH(5), .DATA_WIDTH(48), .BE_WIDTH(6)) bus0 ();
  rx_ring_ram_if #(.ADDR_WIDTH(5), .DATA_WIDTH(48), .BE_WIDTH(6)) bus1 ();

  assign bus1.wr_en      = bus0.wr_en;
  assign bus1.wr_addr    = bus0.wr_addr;
  assign bus1.wr_data    = bus0.wr_data;
  assign bus1.wr_byte_en = bus0.wr_byte_en;
  assign bus1.rd_addr    = bus0.rd_addr;

  rx_ring_ram #(.OUTPUT_REG(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  rx_ring_ram #(.OUTPUT_REG(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rx_ring_word_t model [32];
  sb_item_t      q1 [$];
  sb_item_t      q2 [$];
  int            n_checks;
  int            n_pass;

  task automatic check_eq(input string tag, input rx_ring_word_t got, input rx_ring_word_t exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: queue what the read port must show, advance, update model, compare.
  task automatic step(input bit chk, input string tag);
    sb_item_t      it;
    sb_item_t      old;
    logic          rst_at_edge;
    rx_ring_word_t exp2;
    it.data     = rst ? '0 : model[bus0.rd_addr];
    it.chk      = chk;
    it.tag      = tag;
    rst_at_edge = rst;
    q1.push_back(it);
    q2.push_back(it);
    @(posedge clk);
    if (bus0.wr_en) begin
      for (int b = 0; b < 6; b++) begin
        if (bus0.wr_byte_en[b]) model[bus0.wr_addr][b*8 +: 8] = bus0.wr_data[b*8 +: 8];
      end
    end
    #1;
    old = q1.pop_front();
    if (old.chk) check_eq(old.tag, bus0.rd_data, old.data);
    if (q2.size() == 2) begin
      old  = q2.pop_front();
      exp2 = rst_at_edge ? '0 : old.data;
      if (old.chk || (rst_at_edge && chk)) check_eq({tag, "_o2"}, bus1.rd_data, exp2);
    end
  endtask

  task automatic drive_wr(input logic en, input rx_ring_addr_t a, input rx_ring_word_t d,
                          input logic [5:0] be);
    bus0.wr_en      = en;
    bus0.wr_addr    = a;
    bus0.wr_data    = d;
    bus0.wr_byte_en = be;
  endtask

  initial begin
    rx_ring_word_t d;
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst = 1'b1;
    drive_wr(1'b0, '0, '0, '0);
    bus0.rd_addr = '0;
    #1;
    step(1, "rst0");
    step(1, "rst1");
    check_eq("rst_const", bus0.rd_data, 48'h0);
    rst = 1'b0;

    for (int i = 1; i <= 32; i++) begin
      d = 48'hFFFF_FFFF_FFFF - rx_ring_word_t'(i - 1);
      drive_wr(1'b1, rx_ring_addr_t'(i), d, 6'h3F);
      step(0, "fill");
    end
    drive_wr(1'b0, '0, '0, '0);
    for (int i = 1; i <= 32; i++) begin
      bus0.rd_addr = rx_ring_addr_t'(i);
      step(1, "sweep");
      if (i == 32) check_eq("sweep_wrap0", bus0.rd_data, 48'hFFFF_FFFF_FFE0);
    end

    drive_wr(1'b1, 5'd5, 48'h0, 6'h3F);
    step(0, "merge_w0");
    drive_wr(1'b1, 5'd5, 48'hAABB_CCDD_EEFF, 6'b000101);
    step(0, "merge_w1");
    drive_wr(1'b0, '0, '0, '0);
    bus0.rd_addr = 5'd5;
    step(1, "merge");
    check_eq("merge_const", bus0.rd_data, 48'h0000_00DD_00FF);

    drive_wr(1'b1, 5'd7, 48'h1234, 6'h3F);
    step(0, "coll_w0");
    drive_wr(1'b1, 5'd7, 48'h5678, 6'h3F);
    bus0.rd_addr = 5'd7;
    step(1, "rdfirst");
    check_eq("rdfirst_const", bus0.rd_data, 48'h1234);
    drive_wr(1'b0, '0, '0, '0);
    step(1, "rdnext");
    check_eq("rdnext_const", bus0.rd_data, 48'h5678);

    rst = 1'b1;
    drive_wr(1'b1, 5'd9, 48'h9999_0000_9999, 6'h3F);
    step(1, "rst_mid");
    check_eq("rst_mid_const", bus0.rd_data, 48'h0);
    rst = 1'b0;
    drive_wr(1'b0, '0, '0, '0);
    step(1, "post_rst");
    check_eq("post_rst_const", bus0.rd_data, 48'h5678);
    bus0.rd_addr = 5'd9;
    step(1, "wr_in_rst");
    check_eq("wr_in_rst_const", bus0.rd_data, 48'h9999_0000_9999);

    drive_wr(1'b0, 5'd3, 48'hDEAD_BEEF_0000, 6'h3F);
    step(0, "gate_w");
    bus0.rd_addr = 5'd3;
    step(1, "gate");
    check_eq("gate_const", bus0.rd_data, 48'hFFFF_FFFF_FFFD);

    for (int i = 0; i < 40; i++) begin
      drive_wr(1'($urandom_range(0, 1)), rx_ring_addr_t'($urandom_range(0, 31)),
               {16'($urandom), 32'($urandom)}, 6'($urandom_range(0, 63)));
      bus0.rd_addr = rx_ring_addr_t'($urandom_range(0, 31));
      step(1, "rand");
    end
    drive_wr(1'b0, '0, '0, '0);
    step(1, "flush0");
    step(1, "flush1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
